// File: rtl/key_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_pkg : shared debounce FSM state encoding and ms-to-cycles sizing helper
// Revision: 1.0
// ----------------------------------------------------------------------------
package key_pkg;

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_FILT_DN = 2'd1,
        ST_DOWN    = 2'd2,
        ST_FILT_UP = 2'd3
    } key_state_t;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_2ff : generic two-flop synchroniser with configurable reset value
// Revision: 1.0
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_debounce : push-button synchroniser/debouncer with press/release strobes
// Optional long-press strobe when built with LONG_PRESS_EN.   Revision: 1.0
// ----------------------------------------------------------------------------
module key_debounce
    import key_pkg::*;
#(
    parameter int   CLK_FREQ_HZ = 50_000_000,
    parameter int   DEBOUNCE_MS = 20,
    parameter logic KEY_ACTIVE  = 1'b0,
    parameter int   LONG_MS     = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic key_out,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int DEB_CYCLES = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
    localparam int CNT_W      = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             key_sync;
    logic             pressed_s;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_d, release_d, out_d;

    // Flops start at the idle level so leaving reset never looks like a press.
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (~KEY_ACTIVE)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key_in),
        .q     (key_sync)
    );

    assign pressed_s = (key_sync == KEY_ACTIVE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_UP: begin
                if (pressed_s) begin
                    state_d = ST_FILT_DN;
                    cnt_d   = '0;
                end
            end
            ST_FILT_DN: begin
                if (!pressed_s) begin
                    state_d = ST_UP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DOWN: begin
                if (!pressed_s) begin
                    state_d = ST_FILT_UP;
                    cnt_d   = '0;
                end
            end
            ST_FILT_UP: begin
                if (pressed_s) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_UP;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_UP;
                cnt_d   = '0;
            end
        endcase
    end

    assign out_d = (state_d == ST_DOWN) || (state_d == ST_FILT_UP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_UP;
            cnt_q       <= '0;
            key_out     <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_out     <= out_d;
            key_press   <= press_d;
            key_release <= release_d;
        end
    end

`ifdef LONG_PRESS_EN
    localparam int LONG_CYCLES = ms_to_cycles(CLK_FREQ_HZ, LONG_MS);
    localparam int HOLD_W      = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_d, long_q;

    // Saturation at HOLD_MAX is what limits key_long to one pulse per press.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (state_q == ST_FILT_DN && state_d == ST_DOWN) begin
            hold_d = '0;
        end else if (state_q == ST_DOWN && hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
            long_d = (hold_q == HOLD_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign key_long = long_q;
`else
    logic unused_long_ms;
    assign unused_long_ms = (LONG_MS != 0);
    assign key_long       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_key_debounce : self-checking bench for key_debounce (DEB_CYCLES=10, LONG=50)
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_key_debounce;

    localparam int DEB  = 10;
    localparam int LONG = 50;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_in = 1'b0;
    logic key_out, key_press, key_release, key_long;

    always #5 clk = ~clk;

    key_debounce #(
        .CLK_FREQ_HZ (1000),
        .DEBOUNCE_MS (10),
        .KEY_ACTIVE  (1'b0),
        .LONG_MS     (50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_in      (key_in),
        .key_out     (key_out),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    int errors = 0;
    int checks = 0;

    // Reference: output flips after DEB+1 consecutive synchronised samples disagree with it.
    bit hist[$];
    bit m_out, m_press, m_rel, m_long;
    int run, hold;
    int n_press, n_rel, n_long;

    typedef struct {
        bit key;
        int n;
        bit e_out;
        bit e_press;
        bit e_rel;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist    = {1'b1, 1'b1};
        m_out   = 1'b0;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        run     = 0;
        hold    = 0;
    endtask

    task automatic model_edge();
        bit p;
        bit settled;
        p = (hist.pop_front() == 1'b0);
        hist.push_back(key_in);
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        settled = m_out && (run == 0);
        if (p != m_out) begin
            run++;
            if (run == DEB + 1) begin
                m_out   = p;
                run     = 0;
                m_press = p;
                m_rel   = !p;
                if (p) hold = 0;
            end
        end else begin
            run = 0;
        end
`ifdef LONG_PRESS_EN
        if (settled && hold < LONG) begin
            hold++;
            if (hold == LONG) m_long = 1'b1;
        end
`endif
    endtask

    // Drive on the falling edge, advance the model on the rising edge, sample 1 ns later.
    task automatic cyc(input bit k, input bit r);
        @(negedge clk);
        key_in = k;
        reset  = r;
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        #1;
        if (key_press)   n_press++;
        if (key_release) n_rel++;
        if (key_long)    n_long++;
        check("model_out", key_out, m_out);
        check("model_press", key_press, m_press);
        check("model_release", key_release, m_rel);
        check("model_long", key_long, m_long);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, r0, l0, press_edge, long_edge, long_cnt;
        model_reset();
        n_press = 0;
        n_rel   = 0;
        n_long  = 0;

        // Reset held with the key already at the pressed level
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0);
            check("rst_out", key_out, 1'b0);
            check("rst_press", key_press, 1'b0);
            check("rst_release", key_release, 1'b0);
            check("rst_long", key_long, 1'b0);
        end
        for (int i = 1; i <= 13; i++) begin
            cyc(1'b0, 1'b1);
            if (i < 13) check("rst_rel_out_low", key_out, 1'b0);
            else begin
                check("rst_rel_out_e13", key_out, 1'b1);
                check("rst_rel_press_e13", key_press, 1'b1);
            end
        end
        cyc(1'b0, 1'b1);
        check("rst_rel_press_e14", key_press, 1'b0);

        for (int i = 0; i < 30; i++) cyc(1'b1, 1'b1);
        check("idle_out", key_out, 1'b0);

        // Clean press, release glitch, clean release
        vecs[0] = '{1'b0, 12, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1,  1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1,  1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 5,  1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 20, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 12, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1,  1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1,  1'b0, 1'b0, 1'b0};
        r0 = 0;
        for (int v = 0; v < 8; v++) begin
            if (v == 3) r0 = n_rel;
            for (int c = 0; c < vecs[v].n; c++) cyc(vecs[v].key, 1'b1);
            if (v == 4) check_int("glitch_no_release", n_rel - r0, 0);
            check($sformatf("vec%0d_out", v), key_out, vecs[v].e_out);
            check($sformatf("vec%0d_press", v), key_press, vecs[v].e_press);
            check($sformatf("vec%0d_release", v), key_release, vecs[v].e_rel);
        end

        // Bounce train, toggling every 3 cycles, then settle pressed
        p0 = n_press;
        r0 = n_rel;
        for (int i = 0; i < 30; i++) cyc(((i / 3) % 2) == 1, 1'b1);
        check_int("bounce_no_press", n_press - p0, 0);
        check_int("bounce_no_release", n_rel - r0, 0);
        for (int i = 1; i <= 13; i++) begin
            cyc(1'b0, 1'b1);
            if (i == 12) check("bounce_out_e12", key_out, 1'b0);
        end
        check("bounce_press_e13", key_press, 1'b1);
        check_int("bounce_single_press", n_press - p0, 1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);

        // Asynchronous reset while held
        check("midhold_out_before", key_out, 1'b1);
        r0 = n_rel;
        #2 reset = 1'b0;
        #1;
        check("midhold_async_out", key_out, 1'b0);
        check("midhold_async_release", key_release, 1'b0);
        model_reset();
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        p0 = n_press;
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1);
        check_int("midhold_no_release", n_rel - r0, 0);
        check_int("midhold_no_press", n_press - p0, 0);

        // Long hold, then release
        press_edge = -1;
        long_edge  = -1;
        long_cnt   = 0;
        for (int i = 1; i <= 150; i++) begin
            cyc(i > 120, 1'b1);
            if (key_press && press_edge < 0) press_edge = i;
            if (key_long) begin
                long_cnt++;
                long_edge = i;
            end
        end
        check_int("long_press_edge", press_edge, 13);
`ifdef LONG_PRESS_EN
        check_int("long_count", long_cnt, 1);
        check_int("long_delay", long_edge - press_edge, LONG);
`else
        check_int("long_count", long_cnt, 0);
`endif

        // Random bursts against the reference model
        l0 = n_long;
        for (int b = 0; b < 200; b++) begin
            if ($urandom_range(0, 39) == 0) begin
                cyc(1'b1, 1'b0);
                cyc(1'b1, 1'b0);
            end else begin
                bit lvl;
                int len;
                lvl = 1'($urandom_range(0, 1));
                len = $urandom_range(1, 25);
                for (int c = 0; c < len; c++) cyc(lvl, 1'b1);
            end
        end
`ifndef LONG_PRESS_EN
        check_int("random_no_long", n_long - l0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Conditions one raw mechanical push-button input (board key S1…Sn) before it drives downstream registers such as the d_ff LED stage.
- Synchronises the asynchronous pin into the clk domain and rejects contact bounce with a per-key stability counter.
- Emits a clean pressed level plus one-cycle press and release strobes.
- Runs from the 50 MHz board clock; one instance per key.

Parameters:
- CLK_FREQ_HZ, 50_000_000, clk frequency in Hz.
- DEBOUNCE_MS, 20, required stable time in ms. DEB_CYCLES = (CLK_FREQ_HZ/1000)*DEBOUNCE_MS, must be ≥2.
- KEY_ACTIVE, 1'b0, raw pin level that means "pressed".
- LONG_MS, 1000, long-press threshold in ms (used only with the optional feature). LONG_CYCLES = (CLK_FREQ_HZ/1000)*LONG_MS.

Ports:
- clk  input  1  system clock, 50 MHz crystal.
- reset  input  1  asynchronous, active-low reset (RESET key).
- key_in  input  1  raw, asynchronous, bouncing button pin.
- key_out  output  1  debounced level; 1 = pressed, regardless of KEY_ACTIVE.
- key_press  output  1  one-cycle strobe in the cycle key_out goes 0→1.
- key_release  output  1  one-cycle strobe in the cycle key_out goes 1→0.
- key_long  output  1  one-cycle long-press strobe. Tied to 0 without LONG_PRESS_EN.

Behaviour:
- Reset: asynchronous on reset=0.
  - Both synchroniser flops load ~KEY_ACTIVE (idle level), so release from reset causes no spurious press.
  - FSM goes to UP; counters go to 0.
  - key_out, key_press, key_release and key_long are all 0.
- Synchroniser: 2 flops. pressed_s = (sync2 == KEY_ACTIVE). The FSM uses only pressed_s.
- Debounce counter: width $clog2(DEB_CYCLES).
- FSM, 4 states:
  - UP (key_out=0): pressed_s → FILT_DN with cnt=0.
  - FILT_DN (key_out=0):
    - !pressed_s → UP, cnt=0. Any single bounce sample restarts filtering.
    - Else if cnt==DEB_CYCLES-1 → DOWN, pulse key_press.
    - Else cnt+1.
  - DOWN (key_out=1): !pressed_s → FILT_UP with cnt=0.
  - FILT_UP (key_out=1):
    - pressed_s → DOWN, no strobe.
    - Else if cnt==DEB_CYCLES-1 → UP, pulse key_release.
    - Else cnt+1.
- All outputs are registered. key_out and its strobe change on the same edge.
- Latency: key_out changes on the (DEB_CYCLES+3)th rising edge after key_in settles. That is 2 edges of synchroniser, 1 edge entering FILT_*, and DEB_CYCLES edges of filtering.
- Glitch rejection: any pulse or bounce train shorter than DEB_CYCLES synchronised cycles produces no change on key_out and no strobes.
- Strobes last exactly 1 cycle, never overlap, and strictly alternate press/release.
- The counter never wraps: it is cleared on every FILT_* entry and exit.
- Reset mid-filter or mid-hold returns immediately to UP with outputs 0. No release strobe is generated.

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined:
  - Hold counter, width $clog2(LONG_CYCLES+1), cleared on entry to DOWN from FILT_DN.
  - Increments in DOWN, holds in FILT_UP, saturates at LONG_CYCLES.
  - key_long pulses 1 cycle when the count reaches LONG_CYCLES, at most once per press.
  - A bounce back from FILT_UP to DOWN does not restart the count.
- Undefined:
  - No hold counter is synthesised.
  - key_long is constant 0.
  - All other behaviour is identical.

Decomposition:
- Shared package key_pkg holds:
  - State encodings ST_UP, ST_FILT_DN, ST_DOWN, ST_FILT_UP (2-bit).
  - A ms-to-cycles constant function used by both debounce and long-press sizing.
- One sub-module: sync_2ff, the generic 2-flop synchroniser with reset-value parameter. It is reused for the other board inputs.

Test Plan (sim params CLK_FREQ_HZ=1000, DEBOUNCE_MS=10 → DEB_CYCLES=10; LONG_MS=50):
- Reset check: hold reset=0 with key_in=0 (pressed level), then release.
  → All outputs 0 during reset.
  → key_out rises on the 13th edge after release, with key_press high for exactly that one cycle.
- Clean press: key_in 1→0 held.
  → key_out=1 and key_press=1 on edge 13 after the change.
  → key_press=0 on edge 14.
- Bounce: key_in toggles 0/1 every 3 cycles for 30 cycles, then holds 0.
  → No strobes during the bounce.
  → A single key_press on the 13th edge after the final settle.
- Release glitch: while pressed, drive key_in=1 for 5 cycles.
  → key_out stays 1 and no key_release.
  → A later 1 held for 20 cycles gives key_release on edge 13.
- Reset mid-hold: assert reset with key_out=1.
  → key_out=0 immediately (asynchronous) and no key_release strobe.
- LONG_PRESS_EN defined: hold pressed 120 cycles.
  → key_long pulses once, exactly 50 edges after key_press, and never again before release.
  → With the macro undefined, key_long stays 0 throughout.
